alu_srl_seq: RTL and testbench

ALU_SRL_SEQ -- requirements
Module: alu_srl_seq

---
 rtl/alu_srl_seq.sv | 111 +++++++++++
 tb/tb_alu_srl_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_srl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_srl_seq
//  Brief    : Sequential right shifter. Shifts an N-bit operand right by one
//             bit per clock, logical (zero-fill) or arithmetic (sign-fill),
//             and presents the registered result with a one-cycle done pulse.
//  Options  : define ALU_SRL_SRA_EN to honour the arith input; without it the
//             arith port is present but every shift is logical.
//  Revision : 1.0  initial release
// ============================================================================
module alu_srl_seq #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] S,
  input  logic          arith,
  output logic [N-1:0]  Z,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0] C_CNT_ZERO = '0;
  localparam logic [SW-1:0] C_CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_work;
  logic [N-1:0]  w_work_next;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_next;
  logic          r_fill;
  logic          w_fill_next;
  logic [N-1:0]  r_z;
  logic          w_arith_en;

`ifdef ALU_SRL_SRA_EN
  assign w_arith_en = arith;
`else
  // Sign fill disabled: arith is deliberately masked off.
  assign w_arith_en = arith & 1'b0;
`endif

  // Next-state, working-register and counter logic for the shift sequence.
  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_cnt_next   = r_cnt;
    w_fill_next  = r_fill;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_work_next  = A;
          w_cnt_next   = S;
          // Fill bit is fixed at capture time from the operand MSB.
          w_fill_next  = w_arith_en & A[N-1];
          w_state_next = (S == C_CNT_ZERO) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_work_next = {r_fill, r_work[N-1:1]};
        w_cnt_next  = r_cnt - C_CNT_ONE;
        // Count of one means this edge performs the last shift.
        if (r_cnt <= C_CNT_ONE) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, working registers and result register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_fill  <= 1'b0;
      r_z     <= '0;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_cnt   <= w_cnt_next;
      r_fill  <= w_fill_next;
      // Result is captured on the edge that enters DONE (from IDLE when S=0).
      if (w_state_next == ST_DONE) begin
        r_z <= w_work_next;
      end
    end
  end

  assign Z    = r_z;
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_srl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_srl_seq
//  Brief    : Directed self-checking bench for alu_srl_seq (N=32 and N=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_srl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [31:0] A     = '0;
  logic [4:0]  S     = '0;
  logic        arith = 1'b0;
  logic [31:0] Z;
  logic        busy;
  logic        done;

  logic        start8 = 1'b0;
  logic [7:0]  A8     = '0;
  logic [4:0]  S8     = '0;
  logic        arith8 = 1'b0;
  logic [7:0]  Z8;
  logic        busy8;
  logic        done8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_srl_seq #(.N(32), .SW(5)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .S     (S),
    .arith (arith),
    .Z     (Z),
    .busy  (busy),
    .done  (done)
  );

  alu_srl_seq #(.N(8), .SW(5)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (A8),
    .S     (S8),
    .arith (arith8),
    .Z     (Z8),
    .busy  (busy8),
    .done  (done8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after done.
  task automatic run_op(input string tag, input bit w8, input logic [31:0] a,
                        input int s, input bit ar, input logic [31:0] exp_z);
    int k;
    if (w8) begin
      A8 = a[7:0]; S8 = s[4:0]; arith8 = ar; start8 = 1'b1;
    end else begin
      A = a; S = s[4:0]; arith = ar; start = 1'b1;
    end
    @(negedge clk);
    start  = 1'b0;
    start8 = 1'b0;
    k = 1;
    while (!(w8 ? done8 : done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(s + 1));
    check({tag, " z"}, w8 ? {56'b0, Z8} : {32'b0, Z}, {32'b0, exp_z});
    @(negedge clk);
    check({tag, " done_clr"}, {63'b0, (w8 ? done8 : done)}, 64'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    logic [31:0] zc;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst busy", {63'b0, busy}, 64'd0);
    check("rst done", {63'b0, done}, 64'd0);
    check("rst z", {32'b0, Z}, 64'd0);
    check("rst busy8", {63'b0, busy8}, 64'd0);

    // Basic logical shift, latency S+1
    run_op("lsr4", 1'b0, 32'h8000_0010, 4, 1'b0, 32'h0800_0001);

    // Arithmetic request: sign fill only when the option is built in
`ifdef ALU_SRL_SRA_EN
    run_op("asr4", 1'b0, 32'h8000_0010, 4, 1'b1, 32'hF800_0001);
`else
    run_op("asr4", 1'b0, 32'h8000_0010, 4, 1'b1, 32'h0800_0001);
`endif

    // S=0 completes in one cycle
    run_op("s0", 1'b0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678);

    // S=8 op with start held and inputs changed while busy
    A = 32'hF000_0000; S = 5'd8; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 32'hFFFF_FFFF; S = 5'd1; arith = 1'b1;
    ndone = 0; lat = 0; zc = '0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        ndone++;
        lat = i;
        zc  = Z;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    check("busy_ign ndone", 64'(ndone), 64'd1);
    check("busy_ign latency", 64'(lat), 64'd9);
    check("busy_ign z", {32'b0, zc}, 64'h0000_0000_00F0_0000);

    // Back-to-back: second start in the IDLE cycle right after done
    run_op("b2b_a", 1'b0, 32'hAAAA_5555, 1, 1'b0, 32'h5555_2AAA);
    run_op("b2b_b", 1'b0, 32'h0000_FF00, 8, 1'b0, 32'h0000_00FF);

    // Reset in SHIFT after two shifts of an S=10 op
    A = 32'hDEAD_BEEF; S = 5'd10; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst busy_pre", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", {63'b0, busy}, 64'd0);
    check("midrst done", {63'b0, done}, 64'd0);
    check("midrst z", {32'b0, Z}, 64'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst no_done", 64'(ndone), 64'd0);

    // N=8 with S well beyond the width
`ifdef ALU_SRL_SRA_EN
    run_op("n8 asr20", 1'b1, 32'h0000_0081, 20, 1'b1, 32'h0000_00FF);
`else
    run_op("n8 asr20", 1'b1, 32'h0000_0081, 20, 1'b1, 32'h0000_0000);
`endif
    run_op("n8 lsr20", 1'b1, 32'h0000_0081, 20, 1'b0, 32'h0000_0000);
    run_op("n8 lsr3", 1'b1, 32'h0000_0081, 3, 1'b0, 32'h0000_0010);

    // Logical sweep over small operands and shift amounts
    for (int a = 0; a <= 16; a++) begin
      for (int s = 0; s <= 16; s++) begin
        run_op($sformatf("sweep a=%0d s=%0d", a, s), 1'b0, 32'(a), s, 1'b0,
               32'(a) >> s);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
